// File: rtl/chipper_pkg.sv
// chipper_pkg: flit layout constants, flit type and request-to-flit packing shared by the injector.
package chipper_pkg;
  localparam int FLIT_W = 10;
  localparam int FLIT_VALID_BIT = 9;
  localparam int DEST_MSB = 8;
  localparam int DEST_LSB = 5;
  localparam int DATA_MSB = 4;
  localparam int DATA_LSB = 0;
  typedef logic [FLIT_W-1:0] flit_t;
  function automatic flit_t pack_flit(input logic [DEST_MSB-DEST_LSB:0] dest,
                                      input logic [DATA_MSB-DATA_LSB:0] data);
    return {1'b1, dest, data};
  endfunction
endpackage

// File: rtl/flit_injector_inj_fifo.sv
// inj_fifo: DEPTH-entry flit queue; push ignored when full, pop ignored when empty.
//   clk, rst_n (async active-low); push/din write request; pop read request;
//   dout = head flit or 0 when empty; full, empty status from registered count.
module inj_fifo
  import chipper_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  flit_t din,
  input  logic  pop,
  output flit_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  flit_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic wr_en, rd_en;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/flit_injector.sv
// flit_injector: queues node cache-miss requests and injects one flit per free router slot.
//   clk, rst_n (async active-low); req_valid/req_ready/req_dest/req_data request handshake;
//   slot_free router has room; inj_flit registered head flit; inj_count injected flits;
//   starve head blocked STARVE_LIMIT cycles (only with INJ_STARVE_EN defined, else 0).
module flit_injector
  import chipper_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_dest,
  input  logic [4:0]       req_data,
  input  logic             slot_free,
  output logic [9:0]       inj_flit,
  output logic [CNT_W-1:0] inj_count,
  output logic             starve
);
  logic full, empty, pop;
  flit_t head;
  assign req_ready = ~full;
  assign pop = slot_free & ~empty;
  assign inj_flit = head;
  inj_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (req_valid),
    .din  (pack_flit(req_dest, req_data)),
    .pop  (slot_free),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inj_count <= '0;
    else inj_count <= inj_count + CNT_W'(pop);
`ifdef INJ_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1) < 4 ? 4 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= '0;
    else if (pop || empty) starve_cnt <= '0;
    else if (starve_cnt < SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  assign starve = starve_cnt == SW'(STARVE_LIMIT);
`else
  assign starve = 1'b0;
`endif
endmodule

// File: tb/tb_flit_injector.sv
// tb_flit_injector: directed vectors for flit_injector with hand-computed expectations.
module tb_flit_injector;
  logic clk = 0, rst_n = 0, req_valid = 0, slot_free = 0, req_ready, starve;
  logic [3:0] req_dest = 0;
  logic [4:0] req_data = 0;
  logic [9:0] inj_flit;
  logic [15:0] inj_count;
  int vec_cnt = 0, err_cnt = 0;
`ifdef INJ_STARVE_EN
  localparam bit STARVE_ON = 1;
`else
  localparam bit STARVE_ON = 0;
`endif
  flit_injector dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data), .slot_free(slot_free),
    .inj_flit(inj_flit), .inj_count(inj_count), .starve(starve)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] fl(input int k);
    logic [3:0] d;
    logic [4:0] p;
    d = 4'(k);
    p = 5'(k + 16);
    return {1'b1, d, p};
  endfunction
  task automatic req(input int k);
    logic [9:0] f;
    f = fl(k);
    req_valid = 1;
    req_dest = f[8:5];
    req_data = f[4:0];
  endtask
  initial begin
    req_valid = 1; req_dest = 4'h3; req_data = 5'h15;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_flit", inj_flit, 0);
    chk("rst_count", inj_count, 0);
    chk("rst_starve", starve, 0);
    req_valid = 0; rst_n = 1;
    step();
    chk("rst_nopush", inj_flit, 0);
    slot_free = 1; req_valid = 1; req_dest = 4'h3; req_data = 5'h15;
    step();
    req_valid = 0;
    chk("single_flit", inj_flit, 10'h275);
    chk("single_cnt0", inj_count, 0);
    step();
    chk("single_drained", inj_flit, 0);
    chk("single_cnt1", inj_count, 1);
    step();
    chk("empty_nopop", inj_count, 1);
    slot_free = 0;
    for (int i = 1; i <= 5; i++) begin
      req(i);
      chk($sformatf("fill_ready%0d", i), req_ready, i <= 4);
      step();
    end
    req_valid = 0;
    chk("full_ready", req_ready, 0);
    chk("full_head", inj_flit, fl(1));
    slot_free = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d", i), inj_flit, fl(i));
      step();
    end
    chk("drain_empty", inj_flit, 0);
    chk("drain_cnt", inj_count, 5);
    slot_free = 0;
    req(6); step();
    req(7); step();
    req(8); slot_free = 1;
    step();
    req_valid = 0;
    chk("conc_head", inj_flit, fl(7));
    chk("conc_cnt", inj_count, 6);
    chk("conc_ready", req_ready, 1);
    step();
    chk("conc_next", inj_flit, fl(8));
    step();
    chk("conc_empty", inj_flit, 0);
    chk("conc_total", inj_count, 8);
    slot_free = 0;
    req(9); step();
    req_valid = 0;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("starve_c%0d", c), starve, STARVE_ON && c >= 15);
    end
    chk("starve_head", inj_flit, fl(9));
    slot_free = 1;
    step();
    chk("starve_clear", starve, 0);
    chk("starve_popcnt", inj_count, 9);
    chk("starve_empty", inj_flit, 0);
    slot_free = 0;
    for (int i = 10; i <= 12; i++) begin
      req(i); step();
    end
    req_valid = 0;
    chk("mid_head", inj_flit, fl(10));
    #2 rst_n = 0;
    #1;
    chk("arst_flit", inj_flit, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_count", inj_count, 0);
    step();
    rst_n = 1;
    step();
    chk("post_flit", inj_flit, 0);
    chk("post_ready", req_ready, 1);
    slot_free = 1;
    step();
    chk("post_count", inj_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
